// File: rtl/unidade_de_controle_multiciclo_if.sv
// Bus between the multi-cycle control unit and the Zeus datapath:
// the instruction/flag/handshake inputs and the control strobes.
interface unidade_de_controle_multiciclo_if #(
  parameter int OP_W  = 6,
  parameter int ALU_W = 6
);
  logic [OP_W-1:0]  Op_Code;
  logic             Zero;
  logic             Negativo;
  logic             Mem_Ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             RegWrite;
  logic             AluSrc;
  logic             ALUOp;
  logic [1:0]       PCSrc;
  logic             MemWrite;
  logic             MemRead;
  logic             MemToReg;
  logic [ALU_W-1:0] Sinal_da_Conta;
  logic [2:0]       Estado;
  logic             Illegal_Op;
  logic             Erro_Mem;

  // Control unit side: consumes opcode/flags/handshake, drives strobes.
  modport master (
    input  Op_Code, Zero, Negativo, Mem_Ready,
    output PCWrite, IRWrite, RegDst, RegWrite, AluSrc, ALUOp, PCSrc,
           MemWrite, MemRead, MemToReg, Sinal_da_Conta, Estado,
           Illegal_Op, Erro_Mem
  );

  // Datapath side: supplies opcode/flags/handshake, consumes strobes.
  modport slave (
    output Op_Code, Zero, Negativo, Mem_Ready,
    input  PCWrite, IRWrite, RegDst, RegWrite, AluSrc, ALUOp, PCSrc,
           MemWrite, MemRead, MemToReg, Sinal_da_Conta, Estado,
           Illegal_Op, Erro_Mem
  );
endinterface

// File: rtl/unidade_de_controle_multiciclo.sv
// Multi-cycle control unit for the Zeus processor: sequences each
// instruction through fetch/decode/execute/memory/write-back, waits on
// the memory handshake with a timeout, and flags illegal opcodes.
module unidade_de_controle_multiciclo #(
  parameter int               OP_W     = 6,
  parameter int               ALU_W    = 6,
  parameter logic [ALU_W-1:0] ALU_ADD  = 6'b000000,
  parameter logic [ALU_W-1:0] ALU_SUB  = 6'b000100,
  parameter int               WAIT_MAX = 15
) (
  input  logic                              Clock,
  input  logic                              Reset,
  unidade_de_controle_multiciclo_if.master  bus
);

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    BUSCA      = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITA    = 3'd5,
    ERRO       = 3'd6,
    INVALIDO   = 3'd7
  } estado_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BLEZ = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BGTZ = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(8);

  localparam int              CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  estado_t          state_q, state_d;
  logic [OP_W-1:0]  op_reg_q, op_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             erro_mem_q, erro_mem_d;

  logic timeout;
  logic waiting;

  // State, latched opcode, wait counter and sticky error flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= INICIO;
      op_reg_q   <= '0;
      cnt_q      <= '0;
      erro_mem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_reg_q   <= op_reg_d;
      cnt_q      <= cnt_d;
      erro_mem_q <= erro_mem_d;
    end
  end

  // Next-state logic; Mem_Ready on the last allowed cycle beats the timeout.
  always_comb begin
    state_d    = state_q;
    op_reg_d   = op_reg_q;
    erro_mem_d = erro_mem_q;
    timeout    = (cnt_q == WAIT_LIM) && !bus.Mem_Ready;
    waiting    = (state_q == BUSCA) || (state_q == MEMORIA);
    case (state_q)
      INICIO: state_d = BUSCA;
      BUSCA: begin
        if (bus.Mem_Ready) begin
          state_d = DECODIFICA;
        end else if (timeout) begin
          state_d    = ERRO;
          erro_mem_d = 1'b1;
        end
      end
      DECODIFICA: begin
        op_reg_d = bus.Op_Code;
        if (bus.Op_Code <= OP_J) state_d = EXECUTA;
        else                     state_d = BUSCA;
      end
      EXECUTA: begin
        if ((op_reg_q == OP_R) || (op_reg_q == OP_ADDI))     state_d = ESCRITA;
        else if ((op_reg_q == OP_LW) || (op_reg_q == OP_SW)) state_d = MEMORIA;
        else                                                 state_d = BUSCA;
      end
      MEMORIA: begin
        if (bus.Mem_Ready) begin
          if (op_reg_q == OP_LW) state_d = ESCRITA;
          else                   state_d = BUSCA;
        end else if (timeout) begin
          state_d    = ERRO;
          erro_mem_d = 1'b1;
        end
      end
      ESCRITA: state_d = BUSCA;
      default: begin
        // ERRO and the unused encoding both lock up until reset.
        state_d    = state_q;
        erro_mem_d = 1'b1;
      end
    endcase
    // Count only cycles spent waiting in place; any entry or exit clears it.
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
    else                                 cnt_d = '0;
  end

  // Moore outputs from state and latched opcode, plus Mem_Ready-qualified fetch strobes.
  always_comb begin
    bus.PCWrite        = 1'b0;
    bus.IRWrite        = 1'b0;
    bus.RegDst         = 1'b0;
    bus.RegWrite       = 1'b0;
    bus.AluSrc         = 1'b0;
    bus.ALUOp          = 1'b0;
    bus.PCSrc          = 2'd0;
    bus.MemWrite       = 1'b0;
    bus.MemRead        = 1'b0;
    bus.MemToReg       = 1'b0;
    bus.Sinal_da_Conta = '0;
    bus.Illegal_Op     = 1'b0;
    bus.Estado         = state_q;
    bus.Erro_Mem       = erro_mem_q;
    case (state_q)
      BUSCA: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = bus.Mem_Ready;
        bus.PCWrite = bus.Mem_Ready;
      end
      DECODIFICA: begin
        if (!(bus.Op_Code <= OP_J)) bus.Illegal_Op = 1'b1;
      end
      EXECUTA: begin
        case (op_reg_q)
          OP_R: bus.ALUOp = 1'b1;
          OP_ADDI, OP_LW, OP_SW: begin
            bus.AluSrc         = 1'b1;
            bus.Sinal_da_Conta = ALU_ADD;
          end
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            bus.Sinal_da_Conta = ALU_SUB;
            bus.PCSrc          = 2'd1;
            case (op_reg_q)
              OP_BEQ:  bus.PCWrite = bus.Zero;
              OP_BNE:  bus.PCWrite = !bus.Zero;
              OP_BLEZ: bus.PCWrite = bus.Zero || bus.Negativo;
              default: bus.PCWrite = !bus.Zero && !bus.Negativo;
            endcase
          end
          OP_J: begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 2'd2;
          end
          default: ;
        endcase
      end
      MEMORIA: begin
        bus.AluSrc         = 1'b1;
        bus.Sinal_da_Conta = ALU_ADD;
        if (op_reg_q == OP_LW) bus.MemRead  = 1'b1;
        if (op_reg_q == OP_SW) bus.MemWrite = 1'b1;
      end
      ESCRITA: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = (op_reg_q == OP_R);
        bus.MemToReg = (op_reg_q == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_de_controle_multiciclo.sv
// Bench for the Zeus multi-cycle control unit: per-cycle expected output
// vectors go through a scoreboard queue and are compared mid-cycle.
module tb_unidade_de_controle_multiciclo;

  typedef logic [21:0] vec_t; // {Estado[2:0], flags[10:0], PCSrc[1:0], Sinal[5:0]}

  localparam logic [10:0] PCW  = 11'd1;
  localparam logic [10:0] IRW  = 11'd2;
  localparam logic [10:0] RDST = 11'd4;
  localparam logic [10:0] RWR  = 11'd8;
  localparam logic [10:0] ASRC = 11'd16;
  localparam logic [10:0] AOP  = 11'd32;
  localparam logic [10:0] MWR  = 11'd64;
  localparam logic [10:0] MRD  = 11'd128;
  localparam logic [10:0] M2R  = 11'd256;
  localparam logic [10:0] ILL  = 11'd512;
  localparam logic [10:0] ERR  = 11'd1024;

  localparam logic [5:0] ADD = 6'b000000;
  localparam logic [5:0] SUB = 6'b000100;

  logic Clock;
  logic Reset;

  unidade_de_controle_multiciclo_if #(.OP_W(6), .ALU_W(6)) bus ();

  unidade_de_controle_multiciclo #(
    .OP_W(6), .ALU_W(6), .ALU_ADD(6'b000000), .ALU_SUB(6'b000100), .WAIT_MAX(15)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [2:0] st, input logic [10:0] f,
                              input logic [1:0] pcs, input logic [5:0] sn);
    return {st, f, pcs, sn};
  endfunction

  function automatic vec_t observe();
    return {bus.Estado,
            bus.Erro_Mem, bus.Illegal_Op, bus.MemToReg, bus.MemRead, bus.MemWrite,
            bus.ALUOp, bus.AluSrc, bus.RegWrite, bus.RegDst, bus.IRWrite, bus.PCWrite,
            bus.PCSrc, bus.Sinal_da_Conta};
  endfunction

  task automatic check_vec(input string tag, input vec_t got, input vec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h (st=%0d) expected=%h (st=%0d)",
               tag, got, got[21:19], exp, exp[21:19]);
    end
  endtask

  // Pop the oldest expectation and compare it with the outputs right now.
  task automatic sb_check(input string tag, input vec_t e);
    vec_t x;
    exp_q.push_back(e);
    x = exp_q.pop_front();
    check_vec(tag, observe(), x);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, return at next posedge+1.
  task automatic step(input string tag, input logic [5:0] op, input logic z,
                      input logic n, input logic mr, input vec_t e);
    vec_t x;
    bus.Op_Code   = op;
    bus.Zero      = z;
    bus.Negativo  = n;
    bus.Mem_Ready = mr;
    exp_q.push_back(e);
    @(negedge Clock);
    x = exp_q.pop_front();
    check_vec(tag, observe(), x);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    sb_check("rst_async", '0);
    @(posedge Clock);
    #1;
    sb_check("rst_hold", '0);
    Reset = 1'b0;
    step("inicio", 6'd0, 1'b0, 1'b0, 1'b1, mk(3'd0, 11'd0, 2'd0, 6'd0));
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] op);
    step({tag, "_busca"}, op, 1'b0, 1'b0, 1'b1, mk(3'd1, MRD | IRW | PCW, 2'd0, 6'd0));
    step({tag, "_decod"}, op, 1'b0, 1'b0, 1'b1, mk(3'd2, 11'd0, 2'd0, 6'd0));
  endtask

  typedef struct packed {
    logic [5:0] op;
    logic       z;
    logic       n;
    logic       taken;
  } br_t;

  br_t br_tab[8];

  initial begin
    Reset         = 1'b1;
    bus.Op_Code   = '0;
    bus.Zero      = 1'b0;
    bus.Negativo  = 1'b0;
    bus.Mem_Ready = 1'b0;

    br_tab[0] = '{6'd2, 1'b1, 1'b0, 1'b1}; // beq Zero -> taken
    br_tab[1] = '{6'd2, 1'b0, 1'b0, 1'b0};
    br_tab[2] = '{6'd4, 1'b1, 1'b0, 1'b0}; // bne Zero -> not taken
    br_tab[3] = '{6'd4, 1'b0, 1'b1, 1'b1};
    br_tab[4] = '{6'd3, 1'b0, 1'b1, 1'b1}; // blez negative -> taken
    br_tab[5] = '{6'd3, 1'b0, 1'b0, 1'b0};
    br_tab[6] = '{6'd5, 1'b0, 1'b0, 1'b1}; // bgtz positive -> taken
    br_tab[7] = '{6'd5, 1'b0, 1'b1, 1'b0};

    do_reset();

    // R-type
    fetch_decode("rtype", 6'd0);
    step("rtype_exec", 6'd0, 1'b0, 1'b0, 1'b1, mk(3'd3, AOP, 2'd0, 6'd0));
    step("rtype_wb",   6'd0, 1'b0, 1'b0, 1'b1, mk(3'd5, RWR | RDST, 2'd0, 6'd0));

    // addi
    fetch_decode("addi", 6'd1);
    step("addi_exec", 6'd1, 1'b0, 1'b0, 1'b1, mk(3'd3, ASRC, 2'd0, ADD));
    step("addi_wb",   6'd1, 1'b0, 1'b0, 1'b1, mk(3'd5, RWR, 2'd0, 6'd0));

    // lw with three wait cycles in MEMORIA
    fetch_decode("lw", 6'd6);
    step("lw_exec", 6'd6, 1'b0, 1'b0, 1'b1, mk(3'd3, ASRC, 2'd0, ADD));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 6'd6, 1'b0, 1'b0, 1'b0, mk(3'd4, ASRC | MRD, 2'd0, ADD));
    step("lw_mem_rdy", 6'd6, 1'b0, 1'b0, 1'b1, mk(3'd4, ASRC | MRD, 2'd0, ADD));
    step("lw_wb",      6'd6, 1'b0, 1'b0, 1'b1, mk(3'd5, RWR | M2R, 2'd0, 6'd0));

    // sw
    fetch_decode("sw", 6'd7);
    step("sw_exec", 6'd7, 1'b0, 1'b0, 1'b1, mk(3'd3, ASRC, 2'd0, ADD));
    step("sw_mem",  6'd7, 1'b0, 1'b0, 1'b1, mk(3'd4, ASRC | MWR, 2'd0, ADD));

    // Branches
    foreach (br_tab[i]) begin
      fetch_decode("br", br_tab[i].op);
      step("br_exec", br_tab[i].op, br_tab[i].z, br_tab[i].n, 1'b1,
           mk(3'd3, br_tab[i].taken ? PCW : 11'd0, 2'd1, SUB));
    end

    // Jump
    fetch_decode("j", 6'd8);
    step("j_exec", 6'd8, 1'b0, 1'b0, 1'b1, mk(3'd3, PCW, 2'd2, 6'd0));

    // Illegal opcode: one-cycle pulse, straight back to BUSCA
    step("ill_busca", 6'h3f, 1'b0, 1'b0, 1'b1, mk(3'd1, MRD | IRW | PCW, 2'd0, 6'd0));
    step("ill_decod", 6'h3f, 1'b0, 1'b0, 1'b1, mk(3'd2, ILL, 2'd0, 6'd0));
    step("ill_next",  6'd8,  1'b0, 1'b0, 1'b0, mk(3'd1, MRD, 2'd0, 6'd0));
    step("ill_next2", 6'd8,  1'b0, 1'b0, 1'b1, mk(3'd1, MRD | IRW | PCW, 2'd0, 6'd0));
    step("ill_j_dec", 6'd8,  1'b0, 1'b0, 1'b1, mk(3'd2, 11'd0, 2'd0, 6'd0));
    step("ill_j_exe", 6'd8,  1'b0, 1'b0, 1'b1, mk(3'd3, PCW, 2'd2, 6'd0));

    // Near-miss: Mem_Ready on the 16th BUSCA cycle still decodes normally
    for (int i = 0; i < 15; i++)
      step("nm_wait", 6'd8, 1'b0, 1'b0, 1'b0, mk(3'd1, MRD, 2'd0, 6'd0));
    step("nm_last", 6'd8, 1'b0, 1'b0, 1'b1, mk(3'd1, MRD | IRW | PCW, 2'd0, 6'd0));
    step("nm_decod", 6'd8, 1'b0, 1'b0, 1'b1, mk(3'd2, 11'd0, 2'd0, 6'd0));
    step("nm_exec",  6'd8, 1'b0, 1'b0, 1'b1, mk(3'd3, PCW, 2'd2, 6'd0));

    // Timeout: 16 cycles without Mem_Ready -> ERRO, sticky
    for (int i = 0; i < 16; i++)
      step("to_wait", 6'd0, 1'b0, 1'b0, 1'b0, mk(3'd1, MRD, 2'd0, 6'd0));
    step("to_erro0", 6'd0, 1'b0, 1'b0, 1'b0, mk(3'd6, ERR, 2'd0, 6'd0));
    step("to_erro1", 6'd0, 1'b1, 1'b0, 1'b1, mk(3'd6, ERR, 2'd0, 6'd0));
    step("to_erro2", 6'd6, 1'b0, 1'b1, 1'b1, mk(3'd6, ERR, 2'd0, 6'd0));

    do_reset();

    // sw aborted by reset in MEMORIA
    fetch_decode("swr", 6'd7);
    step("swr_exec", 6'd7, 1'b0, 1'b0, 1'b1, mk(3'd3, ASRC, 2'd0, ADD));
    step("swr_mem",  6'd7, 1'b0, 1'b0, 1'b0, mk(3'd4, ASRC | MWR, 2'd0, ADD));
    bus.Mem_Ready = 1'b0;
    #2;
    sb_check("swr_pre_rst", mk(3'd4, ASRC | MWR, 2'd0, ADD));
    Reset = 1'b1;
    #1;
    sb_check("swr_rst", '0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    step("swr_inicio", 6'd0, 1'b0, 1'b0, 1'b1, mk(3'd0, 11'd0, 2'd0, 6'd0));
    step("swr_busca",  6'd0, 1'b0, 1'b0, 1'b1, mk(3'd1, MRD | IRW | PCW, 2'd0, 6'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unidade_de_controle_multiciclo.md
Name: unidade_de_controle_multiciclo

Overview:
Multi-cycle control unit for the Zeus processor. It replaces single-cycle opcode decoding with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. The sequence waits on a memory ready handshake, resolves branches from ALU flags, and flags illegal opcodes and memory timeouts. It sits between the instruction register (Op_Code) and the datapath muxes, register file, PC and memory.

Parameters:
OP_W, 6, opcode width.
ALU_W, 6, width of Sinal_da_Conta.
ALU_ADD, 6'b000000, ALU code for addition.
ALU_SUB, 6'b000100, ALU code for subtraction.
WAIT_MAX, 15, maximum wait cycles for Mem_Ready before error (≥1).

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
Op_Code  in  OP_W  opcode from the instruction register (valid from DECODIFICA onward).
Zero  in  1  ALU result == 0.
Negativo  in  1  ALU result sign bit.
Mem_Ready  in  1  memory completes the access this cycle.
PCWrite  out  1  PC load enable.
IRWrite  out  1  instruction register load enable.
RegDst  out  1  1 selects rd, 0 selects rt.
RegWrite  out  1  register file write enable.
AluSrc  out  1  1 selects immediate.
ALUOp  out  1  1 tells the ALU control to decode funct.
PCSrc  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
MemWrite  out  1  memory write strobe.
MemRead  out  1  memory read strobe.
MemToReg  out  1  1 selects memory data for write-back.
Sinal_da_Conta  out  ALU_W  ALU operation when ALUOp=0.
Estado  out  3  current state encoding.
Illegal_Op  out  1  one-cycle pulse on an undefined opcode.
Erro_Mem  out  1  sticky memory-timeout flag.

Behaviour:
- States (Estado): INICIO=0, BUSCA=1, DECODIFICA=2, EXECUTA=3, MEMORIA=4, ESCRITA=5, ERRO=6.
- Outputs are Moore functions of the state and the latched opcode Op_Reg, except the Mem_Ready-qualified strobes noted below. Any output not listed for a state is 0.
- Reset (asynchronous): state INICIO, Op_Reg=0, wait counter=0, Erro_Mem=0. Every output is 0 during reset and in INICIO.
- INICIO: always goes to BUSCA on the next edge.
- BUSCA: MemRead=1. IRWrite=PCWrite=Mem_Ready, PCSrc=0. Goes to DECODIFICA on Mem_Ready, otherwise stays.
- DECODIFICA: Op_Reg<=Op_Code at the end of the cycle.
  - Legal opcodes are 0 (R-type), 1 (addi), 2 (beq), 3 (blez), 4 (bne), 5 (bgtz), 6 (lw), 7 (sw), 8 (j); a legal opcode goes to EXECUTA.
  - Any other opcode: Illegal_Op=1 for this cycle, then BUSCA. The instruction is treated as a nop and the PC has already advanced.
- EXECUTA:
  - R-type: ALUOp=1, AluSrc=0; then ESCRITA.
  - addi: AluSrc=1, Sinal=ALU_ADD; then ESCRITA.
  - lw/sw: AluSrc=1, Sinal=ALU_ADD; then MEMORIA.
  - Branches: AluSrc=0, Sinal=ALU_SUB, PCSrc=1. PCWrite is set when taken: beq Zero; bne !Zero; blez Zero|Negativo; bgtz !Zero&!Negativo. Then BUSCA.
  - j: PCWrite=1, PCSrc=2; then BUSCA.
- MEMORIA: AluSrc=1 and Sinal=ALU_ADD are held. lw: MemRead=1; sw: MemWrite=1. On Mem_Ready, lw goes to ESCRITA and sw goes to BUSCA; otherwise stays.
- ESCRITA: RegWrite=1 for exactly one cycle. R-type: RegDst=1. lw: MemToReg=1. addi: RegDst=0, MemToReg=0. Then BUSCA.
- Instruction latencies with Mem_Ready=1 every cycle, counted from entering BUSCA back to BUSCA:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw, branches and j: 4 cycles, 3 cycles and 3 cycles respectively.
- Timeout: the wait counter clears on every transition into BUSCA or MEMORIA and increments each cycle spent there with Mem_Ready=0.
  - When the counter equals WAIT_MAX and Mem_Ready=0, the next state is ERRO and Erro_Mem<=1.
  - Mem_Ready in the same cycle the counter hits WAIT_MAX wins: normal transition, no error.
- ERRO: all strobes 0, Erro_Mem=1; held until Reset.
- Reset mid-instruction aborts immediately with no partial write. RegWrite, MemWrite and PCWrite drop asynchronously.
- No strobe may ever be asserted in an X state. Unused state encoding 7 behaves as ERRO.

Test Plan:
- Reset, then Mem_Ready=1, Op_Code=0 -> Estado 0,1,2,3,5,1. IRWrite/PCWrite high in cycle 1, ALUOp=1 in cycle 3, RegWrite=1 and RegDst=1 only in cycle 4.
- lw (6) with Mem_Ready held low for 3 cycles in MEMORIA -> MemRead=1 for 4 cycles, then ESCRITA with MemToReg=1 and RegWrite=1, and Erro_Mem=0.
- beq with Zero=1 -> PCWrite=1, PCSrc=1. bne with Zero=1 -> PCWrite=0. blez with Negativo=1 -> taken. bgtz with Zero=0, Negativo=0 -> taken. All return to BUSCA after EXECUTA.
- Op_Code=6'b111111 -> Illegal_Op pulses for 1 cycle in DECODIFICA, then BUSCA, with no RegWrite or MemWrite asserted.
- WAIT_MAX=15, Mem_Ready=0 forever in BUSCA -> ERRO after 16 cycles in BUSCA, Erro_Mem=1 until Reset. A repeat run with Mem_Ready=1 on the 16th cycle gives a normal DECODIFICA.
- sw with Reset asserted during MEMORIA -> MemWrite drops the same cycle, Estado=0, all outputs 0.
